// File: rtl/axis_averager_pkg.sv
// Shared types and width helpers for the AXI-stream block averager.
// The accumulator width formula lives here so every file sizes it the same way.
package axis_averager_pkg;

    typedef enum logic {
        ST_ACCUMULATE = 1'b0,
        ST_HOLD       = 1'b1
    } avg_state_e;

    typedef enum logic [1:0] {
        ACC_KEEP = 2'd0,
        ACC_ADD  = 2'd1,
        ACC_ZERO = 2'd2
    } acc_op_e;

    // Wide enough to hold the sum of n_samples full-scale samples without overflow.
    function automatic int acc_width(input int data_width, input int n_samples);
        return data_width + $clog2(n_samples);
    endfunction

endpackage

// File: rtl/axis_block_averager_accumulator.sv
// Window accumulator with arithmetic-shift result path.
// The result port presents the average of the window including the current sample.
module averager_accumulator
    import axis_averager_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int N_SAMPLES    = 8,
    parameter int OUTPUT_SHIFT = $clog2(N_SAMPLES)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  acc_op_e               acc_op,
    input  logic [DATA_WIDTH-1:0] sample,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int ACC_WIDTH = acc_width(DATA_WIDTH, N_SAMPLES);

    logic signed [ACC_WIDTH-1:0] acc_r;
    logic signed [ACC_WIDTH-1:0] sample_ext_s;
    logic signed [ACC_WIDTH-1:0] sum_s;

    // Sign-extend the sample, add it, and floor-divide via arithmetic shift.
    always_comb begin
        sample_ext_s = ACC_WIDTH'($signed(sample));
        sum_s        = acc_r + sample_ext_s;
        result       = DATA_WIDTH'(sum_s >>> OUTPUT_SHIFT);
    end

    // Accumulator register, driven by the operation chosen in the control FSM.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc_r <= {ACC_WIDTH{1'b0}};
        end else begin
            case (acc_op)
                ACC_ADD:  acc_r <= sum_s;
                ACC_ZERO: acc_r <= {ACC_WIDTH{1'b0}};
                default:  acc_r <= acc_r;
            endcase
        end
    end

endmodule

// File: rtl/axis_block_averager.sv
// AXI-stream block averager: averages every N_SAMPLES accepted samples into one output.
// Control FSM and handshake live here; the arithmetic is in averager_accumulator.
module axis_block_averager
    import axis_averager_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int N_SAMPLES    = 8,
    parameter int OUTPUT_SHIFT = $clog2(N_SAMPLES)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         data_in_valid,
    input  logic [DATA_WIDTH-1:0]        data_in_data,
    output logic                         data_in_ready,
    output logic                         data_out_valid,
    output logic [DATA_WIDTH-1:0]        data_out_data,
    input  logic                         data_out_ready,
    output logic [$clog2(N_SAMPLES):0]   window_count
);

    localparam int CNT_WIDTH = $clog2(N_SAMPLES) + 1;
    localparam logic [CNT_WIDTH-1:0] LAST_COUNT = CNT_WIDTH'(N_SAMPLES - 1);

    avg_state_e            state_r;
    avg_state_e            state_n_s;
    logic [CNT_WIDTH-1:0]  count_r;
    logic [CNT_WIDTH-1:0]  count_n_s;
    logic                  out_valid_r;
    logic                  valid_n_s;
    logic [DATA_WIDTH-1:0] out_data_r;
    logic [DATA_WIDTH-1:0] result_s;
    logic                  in_ready_s;
    logic                  accept_s;
    logic                  load_result_s;
    acc_op_e               acc_op_s;

    averager_accumulator #(
        .DATA_WIDTH   (DATA_WIDTH),
        .N_SAMPLES    (N_SAMPLES),
        .OUTPUT_SHIFT (OUTPUT_SHIFT)
    ) u_accumulator (
        .clock  (clock),
        .reset  (reset),
        .acc_op (acc_op_s),
        .sample (data_in_data),
        .result (result_s)
    );

    // Handshake: input is blocked only while a result is waiting on a stalled sink.
    always_comb begin
        in_ready_s = !(out_valid_r && !data_out_ready);
        accept_s   = data_in_valid && in_ready_s;
    end

    // Next-state logic. Completing a window zeroes acc and count, so an accepted
    // sample in HOLD naturally opens the next window (or closes it when N is 1).
    always_comb begin
        state_n_s     = state_r;
        count_n_s     = count_r;
        valid_n_s     = out_valid_r;
        load_result_s = 1'b0;
        acc_op_s      = ACC_KEEP;
        if (clear) begin
            state_n_s = ST_ACCUMULATE;
            count_n_s = {CNT_WIDTH{1'b0}};
            valid_n_s = 1'b0;
            acc_op_s  = ACC_ZERO;
        end else if (accept_s) begin
            if (count_r == LAST_COUNT) begin
                state_n_s     = ST_HOLD;
                count_n_s     = {CNT_WIDTH{1'b0}};
                valid_n_s     = 1'b1;
                load_result_s = 1'b1;
                acc_op_s      = ACC_ZERO;
            end else begin
                state_n_s = ST_ACCUMULATE;
                count_n_s = count_r + CNT_WIDTH'(1);
                valid_n_s = 1'b0;
                acc_op_s  = ACC_ADD;
            end
        end else begin
            case (state_r)
                ST_ACCUMULATE: begin
                    state_n_s = ST_ACCUMULATE;
                end
                ST_HOLD: begin
                    if (data_out_ready) begin
                        state_n_s = ST_ACCUMULATE;
                        valid_n_s = 1'b0;
                    end else begin
                        state_n_s = ST_HOLD;
                    end
                end
                default: begin
                    state_n_s = ST_ACCUMULATE;
                    count_n_s = {CNT_WIDTH{1'b0}};
                    valid_n_s = 1'b0;
                    acc_op_s  = ACC_ZERO;
                end
            endcase
        end
    end

    // State, count and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_ACCUMULATE;
            count_r     <= {CNT_WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r     <= state_n_s;
            count_r     <= count_n_s;
            out_valid_r <= valid_n_s;
            if (load_result_s) begin
                out_data_r <= result_s;
            end else begin
                out_data_r <= out_data_r;
            end
        end
    end

    assign data_in_ready  = in_ready_s;
    assign data_out_valid = out_valid_r;
    assign data_out_data  = out_data_r;
    assign window_count   = count_r;

endmodule

// File: tb/tb_axis_block_averager.sv
// Directed scoreboard bench for axis_block_averager: three configurations
// (N=4/32b, N=8/16b, N=1/32b) share one clock and reset.
module tb_axis_block_averager;

    typedef struct {
        int inst;
        int val;
    } exp_t;

    logic        clock;
    logic        reset;
    logic [2:0]  clear;
    logic [2:0]  in_valid;
    logic [2:0]  out_ready;
    logic [31:0] din [3];
    wire  [2:0]  in_ready;
    wire  [2:0]  out_valid;
    wire  [31:0] dout_a;
    wire  [15:0] dout_b;
    wire  [31:0] dout_c;
    wire  [2:0]  wc_a;
    wire  [3:0]  wc_b;
    wire  [0:0]  wc_c;

    int     n_tests = 0;
    int     n_fail  = 0;
    exp_t   exp_q[$];
    longint sum  [3] = '{0, 0, 0};
    int     cnt  [3] = '{0, 0, 0};
    int     nsamp[3] = '{4, 8, 1};

    axis_block_averager #(.DATA_WIDTH(32), .N_SAMPLES(4)) dut_a (
        .clock(clock), .reset(reset), .clear(clear[0]),
        .data_in_valid(in_valid[0]), .data_in_data(din[0]), .data_in_ready(in_ready[0]),
        .data_out_valid(out_valid[0]), .data_out_data(dout_a), .data_out_ready(out_ready[0]),
        .window_count(wc_a));

    axis_block_averager #(.DATA_WIDTH(16), .N_SAMPLES(8)) dut_b (
        .clock(clock), .reset(reset), .clear(clear[1]),
        .data_in_valid(in_valid[1]), .data_in_data(din[1][15:0]), .data_in_ready(in_ready[1]),
        .data_out_valid(out_valid[1]), .data_out_data(dout_b), .data_out_ready(out_ready[1]),
        .window_count(wc_b));

    axis_block_averager #(.DATA_WIDTH(32), .N_SAMPLES(1)) dut_c (
        .clock(clock), .reset(reset), .clear(clear[2]),
        .data_in_valid(in_valid[2]), .data_in_data(din[2]), .data_in_ready(in_ready[2]),
        .data_out_valid(out_valid[2]), .data_out_data(dout_c), .data_out_ready(out_ready[2]),
        .window_count(wc_c));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] get_dout(input int i);
        if (i == 0) return dout_a;
        if (i == 1) return {{16{dout_b[15]}}, dout_b};
        return dout_c;
    endfunction

    function automatic longint floor_div(input longint s, input longint n);
        if (s >= 0) return s / n;
        return -((-s + n - 1) / n);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one sample on instance i, wait for its handshake, update the model.
    task automatic send(input int i, input int v);
        int  guard;
        bit  done;
        guard = 0;
        done  = 1'b0;
        in_valid[i] = 1'b1;
        din[i]      = v;
        while (!in_ready[i] && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        check("accept_timeout", 32'(guard < 50), 32'd1);
        @(posedge clock);
        sum[i] += v;
        cnt[i]++;
        if (cnt[i] == nsamp[i]) begin
            exp_q.push_back('{inst: i, val: int'(floor_div(sum[i], longint'(nsamp[i]))) });
            sum[i] = 0;
            cnt[i] = 0;
            done   = 1'b1;
        end
        @(negedge clock);
        in_valid[i] = 1'b0;
        if (done) check("latency_valid", 32'(out_valid[i]), 32'd1);
    endtask

    // Scoreboard: every output handshake must match the oldest expectation.
    always @(negedge clock) begin
        for (int i = 0; i < 3; i++) begin
            if (reset && out_valid[i] && out_ready[i]) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", get_dout(i), 32'hDEAD_BEEF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("out_inst", 32'(i), 32'(e.inst));
                    check("out_data", get_dout(i), 32'(e.val));
                end
            end
        end
    end

    initial begin
        reset     = 1'b0;
        clear     = 3'b000;
        in_valid  = 3'b000;
        out_ready = 3'b111;
        for (int i = 0; i < 3; i++) din[i] = 32'd0;
        repeat (2) @(negedge clock);
        check("rst_valid", 32'(out_valid[0]), 32'd0);
        check("rst_data", dout_a, 32'd0);
        check("rst_wc_a", 32'(wc_a), 32'd0);
        check("rst_wc_b", 32'(wc_b), 32'd0);
        check("rst_wc_c", 32'(wc_c), 32'd0);
        check("rst_ready", 32'(in_ready), 32'h7);
        #2 reset = 1'b1;
        @(negedge clock);
        check("post_rst_ready", 32'(in_ready[0]), 32'd1);

        // Plain window, then a negative window that must floor.
        send(0, 10); send(0, 20); send(0, 30); send(0, 40);
        @(negedge clock);
        check("single_output", 32'(out_valid[0]), 32'd0);
        send(0, -1); send(0, -2); send(0, -3); send(0, -3);
        @(negedge clock);

        // Back-to-back windows with a five-cycle sink stall after the first result.
        out_ready[0] = 1'b0;
        fork
            begin
                send(0, 10); send(0, 20); send(0, 30); send(0, 40);
                send(0, 50); send(0, 60); send(0, 70); send(0, 80);
            end
            begin
                int g;
                g = 0;
                while (!out_valid[0] && g < 50) begin
                    @(negedge clock);
                    g++;
                end
                check("stall_wait", 32'(g < 50), 32'd1);
                for (int k = 0; k < 5; k++) begin
                    check("stall_ready", 32'(in_ready[0]), 32'd0);
                    check("stall_data", dout_a, 32'd25);
                    @(negedge clock);
                end
                @(posedge clock);
                #1 out_ready[0] = 1'b1;
            end
        join
        repeat (2) @(negedge clock);

        // Clear mid-window with a colliding sample.
        send(0, 7); send(0, 9);
        check("wc_two", 32'(wc_a), 32'd2);
        clear[0] = 1'b1; in_valid[0] = 1'b1; din[0] = 32'd99;
        @(posedge clock);
        @(negedge clock);
        clear[0] = 1'b0; in_valid[0] = 1'b0;
        sum[0] = 0; cnt[0] = 0;
        check("clear_wc", 32'(wc_a), 32'd0);
        check("clear_valid", 32'(out_valid[0]), 32'd0);
        send(0, 4); send(0, 4); send(0, 4); send(0, 4);
        @(negedge clock);

        // Full-scale 16-bit windows must not overflow.
        for (int k = 0; k < 8; k++) send(1, 32767);
        @(negedge clock);
        for (int k = 0; k < 8; k++) send(1, -32768);
        @(negedge clock);

        // Single-sample windows pass straight through at full rate.
        send(2, -3); send(2, 5); send(2, 127); send(2, -128);
        @(negedge clock);
        check("pass_done", 32'(out_valid[2]), 32'd0);

        // Reset while holding a stalled result discards it.
        out_ready[0] = 1'b0;
        send(0, 1); send(0, 2); send(0, 3); send(0, 4);
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid[0]), 32'd0);
        check("arst_wc", 32'(wc_a), 32'd0);
        check("arst_ready", 32'(in_ready[0]), 32'd1);
        for (int k = exp_q.size() - 1; k >= 0; k--) begin
            if (exp_q[k].inst == 0) exp_q.delete(k);
        end
        sum[0] = 0; cnt[0] = 0;
        @(negedge clock);
        #2 reset = 1'b1;
        out_ready[0] = 1'b1;
        @(negedge clock);
        check("arst_data", dout_a, 32'd0);
        check("arst_no_valid", 32'(out_valid[0]), 32'd0);

        repeat (3) @(negedge clock);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_block_averager.md
AXIS_BLOCK_AVERAGER -- requirements
Module: axis_block_averager

Interface
REQ-001 Parameter DATA_WIDTH, default 32: sample width in bits, two's complement.
REQ-002 Parameter N_SAMPLES, default 8: samples per averaging window; power of two, 1..1024.
REQ-003 Parameter OUTPUT_SHIFT, default $clog2(N_SAMPLES): right-shift applied to the window sum.
REQ-004 Derived localparam ACC_WIDTH = DATA_WIDTH + $clog2(N_SAMPLES) SHALL size the accumulator.
REQ-005 clock  in  1  single clock; all logic rising-edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 clear  in  1  synchronous window restart.
REQ-008 data_in_valid  in  1  AXI-stream tvalid.
REQ-009 data_in_data  in  DATA_WIDTH  sample.
REQ-010 data_in_ready  out  1  AXI-stream tready.
REQ-011 data_out_valid  out  1  averaged result valid.
REQ-012 data_out_data  out  DATA_WIDTH  averaged result.
REQ-013 data_out_ready  in  1  downstream tready.
REQ-014 window_count  out  $clog2(N_SAMPLES)+1  samples accumulated in the current window.

Function
REQ-015 An input sample SHALL be accepted only on a cycle with data_in_valid and data_in_ready both high.
REQ-016 data_in_ready SHALL equal NOT(data_out_valid AND NOT data_out_ready).
REQ-017 The FSM SHALL have two states: ACCUMULATE and HOLD.
REQ-018 ACCUMULATE, accepted sample, count < N_SAMPLES-1: acc += sign-extended sample; count++.
REQ-019 ACCUMULATE, accepted Nth sample: result = (acc + sample) >>> OUTPUT_SHIFT, truncated to DATA_WIDTH; data_out_valid=1 next cycle; acc=0; count=0; go to HOLD.
REQ-020 HOLD, data_out_ready=1: data_out_valid drops next cycle unless the same cycle also completes a window.
REQ-021 HOLD with data_out_ready=1 and an accepted sample in the same cycle: that sample SHALL start the next window (acc=sample, count=1).
REQ-022 HOLD with data_out_ready=0: data_out_data stable, data_in_ready=0, no samples lost.
REQ-023 Latency: the result SHALL appear exactly one cycle after the accepting edge of the Nth sample.
REQ-024 N_SAMPLES=1: each accepted sample SHALL pass through with one-cycle latency, full throughput when data_out_ready=1.
REQ-025 Shift SHALL be arithmetic; rounding is toward negative infinity.
REQ-026 The accumulator SHALL never overflow for any input sequence (guaranteed by ACC_WIDTH).
REQ-027 clear=1 SHALL zero acc and count, drop any pending output (data_out_valid=0) and enter ACCUMULATE next cycle.
REQ-028 clear SHALL take priority over a same-cycle input handshake; that sample is discarded.
REQ-029 window_count SHALL reflect registered count; it reads N_SAMPLES never, 0 after completion.

Reset
REQ-030 While reset=0: state=ACCUMULATE, acc=0, count=0, data_out_valid=0, data_out_data=0, window_count=0.
REQ-031 data_in_ready SHALL be 1 during and immediately after reset (derived per REQ-016).
REQ-032 Reset asserted mid-window or in HOLD SHALL discard all partial and pending data with no output handshake.

Structure
REQ-033 FSM state enum and the ACC_WIDTH formula SHALL live in a shared package axis_averager_pkg.
REQ-034 The accumulator plus shift SHALL be one sub-module averager_accumulator; FSM and handshake stay in the top.
REQ-035 Parameter elaboration SHALL be expressible in SystemVerilog parameter expressions only ($clog2, arithmetic); no defines.

Verification
REQ-036 N_SAMPLES=4, inputs 10,20,30,40, ready=1 -> one output 25, one cycle after the 40 handshake.
REQ-037 N_SAMPLES=4, inputs -1,-2,-3,-3 -> output -3 (floor of -2.25).
REQ-038 N_SAMPLES=4, 8 samples back-to-back, data_out_ready=0 for 5 cycles after first result -> data_in_ready=0 during stall; outputs 25 then second window average; no sample lost.
REQ-039 N_SAMPLES=8, DATA_WIDTH=16, eight samples 0x7FFF -> output 0x7FFF (no overflow); eight 0x8000 -> 0x8000.
REQ-040 N_SAMPLES=4, two samples accepted then clear=1 with data_in_valid=1 -> window_count=0, sample dropped; next 4 samples 4,4,4,4 -> output 4.
REQ-041 reset pulsed low in HOLD with data_out_ready=0 -> data_out_valid=0 asynchronously, window_count=0, data_in_ready=1.
